// File: rtl/crc_checker.sv
// Serial CRC-8 receiver/checker.
// Rebuilds the LFSR CRC over a serial data word framed by ACTIVE, then checks
// the CRC that follows (framed by Valid) bit by bit against the LFSR contents.
// Reports the received word with pass / fail / frame-error status.
module crc_checker #(
   parameter int unsigned          DATA_WIDTH = 8,
   parameter int unsigned          CRC_WIDTH  = 8,
   parameter logic [CRC_WIDTH-1:0] SEED       = 8'hD8,
   parameter logic [CRC_WIDTH-1:0] TAPS       = 8'h44
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  ACTIVE,
   input  logic                  Valid,
   input  logic                  DATA,
   output logic [DATA_WIDTH-1:0] DATA_OUT,
   output logic                  DONE,
   output logic                  CRC_OK,
   output logic                  CRC_ERR,
   output logic                  FRAME_ERR
);

   localparam int unsigned MAX_W = (DATA_WIDTH > CRC_WIDTH) ? DATA_WIDTH : CRC_WIDTH;
   localparam int unsigned CNT_W = $clog2(MAX_W) + 1;

   typedef enum logic [1:0] {
      IDLE,
      DATA_RX,
      CRC_WAIT,
      CRC_RX
   } state_t;

   state_t                state;
   logic [CRC_WIDTH-1:0]  lfsr;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [CNT_W-1:0]      count;
   logic                  mismatch;

   logic consume_data;
   logic consume_crc;
   logic abort;
   logic finish;
   logic data_last;
   logic crc_last;
   logic crc_bad;

   // One LFSR step over a consumed data bit; the top bit never takes a tap.
   function automatic logic [CRC_WIDTH-1:0] lfsr_step(input logic [CRC_WIDTH-1:0] l,
                                                      input logic d);
      logic                 fb;
      logic [CRC_WIDTH-1:0] n;
      fb = d ^ l[0];
      n  = '0;
      n[CRC_WIDTH-1] = fb;
      for (int unsigned i = 0; i < CRC_WIDTH - 1; i++) begin
         n[i] = l[i+1] ^ (TAPS[i] & fb);
      end
      return n;
   endfunction

   // LSB-first word assembly: new bits enter at the top and the first bit
   // received ends up in position 0 once the word is complete.
   function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] s,
                                                      input logic d);
      logic [DATA_WIDTH-1:0] n;
      n = s >> 1;
      n[DATA_WIDTH-1] = d;
      return n;
   endfunction

   assign data_last = (count == CNT_W'(DATA_WIDTH - 1));
   assign crc_last  = (count == CNT_W'(CRC_WIDTH - 1));
   assign crc_bad   = DATA ^ lfsr[0];

   // Decode which action the current edge takes from state and framing inputs.
   always_comb begin
      consume_data = 1'b0;
      consume_crc  = 1'b0;
      abort        = 1'b0;
      finish       = 1'b0;
      unique case (state)
         IDLE: begin
            consume_data = ACTIVE;
         end
         DATA_RX: begin
            if (ACTIVE && !Valid) consume_data = 1'b1;
            else                  abort        = 1'b1;
         end
         CRC_WAIT: begin
            if (ACTIVE)     abort       = 1'b1;
            else if (Valid) consume_crc = 1'b1;
         end
         CRC_RX: begin
            if (Valid && !ACTIVE) consume_crc = 1'b1;
            else                  abort       = 1'b1;
         end
         default: abort = 1'b1;
      endcase
      finish = consume_crc && crc_last;
   end

   // Frame FSM with LFSR, counter, word assembly and registered status outputs.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= IDLE;
         lfsr      <= SEED;
         shift_reg <= '0;
         count     <= '0;
         mismatch  <= 1'b0;
         DATA_OUT  <= '0;
         DONE      <= 1'b0;
         CRC_OK    <= 1'b0;
         CRC_ERR   <= 1'b0;
         FRAME_ERR <= 1'b0;
      end else begin
         DONE <= 1'b0;
         if (consume_data) begin
            lfsr      <= lfsr_step(lfsr, DATA);
            shift_reg <= shift_in(shift_reg, DATA);
            if (state == IDLE) begin
               CRC_OK    <= 1'b0;
               CRC_ERR   <= 1'b0;
               FRAME_ERR <= 1'b0;
            end
            if (data_last) begin
               state    <= CRC_WAIT;
               count    <= '0;
               mismatch <= 1'b0;
            end else begin
               state <= DATA_RX;
               count <= count + CNT_W'(1);
            end
         end else if (finish) begin
            DONE      <= 1'b1;
            DATA_OUT  <= shift_reg;
            CRC_OK    <= ~(mismatch | crc_bad);
            CRC_ERR   <= mismatch | crc_bad;
            FRAME_ERR <= 1'b0;
            state     <= IDLE;
            lfsr      <= SEED;
            count     <= '0;
            mismatch  <= 1'b0;
         end else if (consume_crc) begin
            mismatch <= mismatch | crc_bad;
            lfsr     <= lfsr >> 1;
            count    <= count + CNT_W'(1);
            state    <= CRC_RX;
         end else if (abort) begin
            // The aborting bit is not consumed and cannot start a new frame.
            DONE      <= 1'b1;
            CRC_OK    <= 1'b0;
            CRC_ERR   <= 1'b1;
            FRAME_ERR <= 1'b1;
            state     <= IDLE;
            lfsr      <= SEED;
            count     <= '0;
            mismatch  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_crc_checker.sv
// Self-checking bench for crc_checker: frames are driven serially, expected
// results are queued at stimulus time and compared when DONE pulses.
module tb_crc_checker;

   logic       CLK;
   logic       RST;
   logic       ACTIVE;
   logic       Valid;
   logic       DATA;
   logic [7:0] DATA_OUT;
   logic       DONE;
   logic       CRC_OK;
   logic       CRC_ERR;
   logic       FRAME_ERR;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   typedef struct {
      logic [7:0] data;
      logic       ok;
      logic       err;
      logic       ferr;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] model_data = 8'h00;

   crc_checker #(
      .DATA_WIDTH(8),
      .CRC_WIDTH (8),
      .SEED      (8'hD8),
      .TAPS      (8'h44)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .ACTIVE   (ACTIVE),
      .Valid    (Valid),
      .DATA     (DATA),
      .DATA_OUT (DATA_OUT),
      .DONE     (DONE),
      .CRC_OK   (CRC_OK),
      .CRC_ERR  (CRC_ERR),
      .FRAME_ERR(FRAME_ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] model_crc(input logic [7:0] d);
      logic [7:0] l;
      logic       fb;
      l = 8'hD8;
      for (int i = 0; i < 8; i++) begin
         fb = d[i] ^ l[0];
         l  = {fb, l[7:1]} ^ (fb ? 8'h44 : 8'h00);
      end
      return l;
   endfunction

   // Scoreboard consumer: every DONE pulse must match the oldest expectation.
   always @(negedge CLK) begin
      exp_t e;
      if (RST === 1'b1 && DONE === 1'b1) begin
         check_eq("done_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("data_out",  32'(DATA_OUT),  32'(e.data));
            check_eq("crc_ok",    32'(CRC_OK),    32'(e.ok));
            check_eq("crc_err",   32'(CRC_ERR),   32'(e.err));
            check_eq("frame_err", 32'(FRAME_ERR), 32'(e.ferr));
         end
      end
   end

   task automatic idle(input int unsigned n);
      repeat (n) begin
         @(negedge CLK);
         ACTIVE = 1'b0;
         Valid  = 1'b0;
         DATA   = 1'b0;
      end
   endtask

   // Drives n_data data bits, gap idle cycles, then n_crc CRC bits; inputs are
   // left on the last bit so the caller decides what the next edge sees.
   task automatic send_frame(input logic [7:0] d, input logic [7:0] c,
                             input int unsigned n_data, input int unsigned gap,
                             input int unsigned n_crc, input bit push);
      exp_t e;
      logic bad;
      if (push) begin
         if (n_data < 8 || n_crc < 8) begin
            e.data = model_data; e.ok = 1'b0; e.err = 1'b1; e.ferr = 1'b1;
         end else begin
            bad        = (c != model_crc(d));
            model_data = d;
            e.data = d; e.ok = ~bad; e.err = bad; e.ferr = 1'b0;
         end
         sb.push_back(e);
      end
      for (int i = 0; i < int'(n_data); i++) begin
         @(negedge CLK);
         if (i == 1) begin
            check_eq("start_clr_ok",   32'(CRC_OK),    32'd0);
            check_eq("start_clr_err",  32'(CRC_ERR),   32'd0);
            check_eq("start_clr_ferr", 32'(FRAME_ERR), 32'd0);
         end
         ACTIVE = 1'b1;
         Valid  = 1'b0;
         DATA   = d[i];
      end
      if (n_data < 8) return;
      idle(gap);
      for (int j = 0; j < int'(n_crc); j++) begin
         @(negedge CLK);
         ACTIVE = 1'b0;
         Valid  = 1'b1;
         DATA   = c[j];
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_data_out"},  32'(DATA_OUT),  32'd0);
      check_eq({tag, "_done"},      32'(DONE),      32'd0);
      check_eq({tag, "_crc_ok"},    32'(CRC_OK),    32'd0);
      check_eq({tag, "_crc_err"},   32'(CRC_ERR),   32'd0);
      check_eq({tag, "_frame_err"}, 32'(FRAME_ERR), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] d;
      RST    = 1'b0;
      ACTIVE = 1'b0;
      Valid  = 1'b0;
      DATA   = 1'b0;
      repeat (3) @(negedge CLK);
      check_all_zero("reset");
      RST = 1'b1;
      idle(2);

      // Known-good frame and the same frame with a corrupted CRC.
      send_frame(8'h00, 8'h14, 8, 0, 8, 1'b1);
      idle(3);
      send_frame(8'h00, 8'h15, 8, 0, 8, 1'b1);
      idle(3);

      // Gap between data and CRC, then a back-to-back frame.
      send_frame(8'h00, 8'h14, 8, 3, 8, 1'b1);
      send_frame(8'hA5, model_crc(8'hA5), 8, 0, 8, 1'b1);
      idle(3);

      // Short data, then short CRC: both abort and keep DATA_OUT.
      send_frame(8'h3C, 8'h00, 5, 0, 0, 1'b1);
      idle(3);
      send_frame(8'h3C, model_crc(8'h3C), 8, 0, 4, 1'b1);
      idle(3);

      // Valid during data is a protocol violation.
      send_frame(8'h77, 8'h00, 3, 0, 0, 1'b1);
      @(negedge CLK);
      ACTIVE = 1'b1;
      Valid  = 1'b1;
      idle(3);

      // Reset after three CRC bits discards the frame with no DONE.
      send_frame(8'h5A, model_crc(8'h5A), 8, 0, 3, 1'b0);
      @(posedge CLK);
      #2 RST = 1'b0;
      #1 check_all_zero("mid_reset");
      model_data = 8'h00;
      idle(2);
      RST = 1'b1;
      idle(1);
      send_frame(8'h00, 8'h14, 8, 0, 8, 1'b1);
      idle(3);

      // Random back-to-back frames, every third one with a flipped CRC bit.
      for (int k = 0; k < 6; k++) begin
         d = 8'($urandom_range(0, 255));
         send_frame(d, model_crc(d) ^ ((k % 3 == 2) ? 8'h10 : 8'h00), 8, 0, 8, 1'b1);
      end
      idle(5);

      check_eq("sb_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/crc_checker.md
# crc_checker

Serial CRC-8 receiver/checker: the receiving end of the serial CRC link driven by `CRC_REG`. It rebuilds the LFSR CRC over a serial data word (qualified by `ACTIVE`), then compares it bit by bit with the CRC that follows (qualified by `Valid`). It reports the received byte together with pass, fail or frame-error status. It sits between the serial line and the byte-level consumer.

## Interface
- `DATA_WIDTH`, 8: data bits per frame.
- `CRC_WIDTH`, 8: CRC/LFSR width.
- `SEED`, 8'hD8: LFSR value loaded at reset and at each frame start.
- `TAPS`, 8'h44: feedback tap mask; bit i=1 XORs feedback into LFSR[i] (i<7).
- `CLK`  in  1  system clock; all logic on rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `ACTIVE`  in  1  high while data bits are on `DATA`.
- `Valid`  in  1  high while CRC bits are on `DATA`.
- `DATA`  in  1  serial bit, LSB first for both data and CRC.
- `DATA_OUT`  out  DATA_WIDTH  last received data word; held.
- `DONE`  out  1  one-cycle pulse when a frame finishes (good, bad or aborted).
- `CRC_OK`  out  1  status: last frame's CRC matched; held.
- `CRC_ERR`  out  1  status: last frame failed (CRC mismatch or frame error); held.
- `FRAME_ERR`  out  1  status: last frame was aborted by a protocol violation; held.

## Operation
- LFSR step, per consumed data bit: fb = DATA ^ L[0]. Then L[7] <= fb, and L[i] <= L[i+1] ^ (TAPS[i] & fb) for i = 0..6.
- FSM states: IDLE, DATA_RX, CRC_WAIT, CRC_RX. Bit counter width is clog2(max(DATA_WIDTH, CRC_WIDTH)) + 1.
- IDLE:
  - L = SEED.
  - On an edge with `ACTIVE`=1: consume the bit and store it in a shift register (first bit → `DATA_OUT[0]` position). Set count=1, clear `CRC_OK`/`CRC_ERR`/`FRAME_ERR`, go to DATA_RX.
  - `Valid` is ignored in IDLE.
- DATA_RX:
  - Each edge with `ACTIVE`=1 consumes one bit.
  - After DATA_WIDTH bits, go to CRC_WAIT with count=0 and mismatch flag=0.
  - `ACTIVE`=0 before DATA_WIDTH bits, or `Valid`=1: abort.
- CRC_WAIT:
  - Idle cycles (`ACTIVE`=0, `Valid`=0) are allowed for an unlimited time.
  - `Valid`=1 consumes the first CRC bit and moves to CRC_RX.
  - `ACTIVE`=1 (with or without `Valid`): abort.
- CRC_RX:
  - Each edge with `Valid`=1 does mismatch |= (DATA != L[0]), then L <= L >> 1 with zero fill.
  - After CRC_WIDTH bits: finish.
  - `Valid`=0 before CRC_WIDTH bits, or `ACTIVE`=1: abort.
- Finish: `DONE`=1, `DATA_OUT` <= shift register. `CRC_OK`=~mismatch_final, `CRC_ERR`=mismatch_final, where mismatch_final includes the current bit. Go to IDLE.
- Abort: `DONE`=1, `CRC_ERR`=1, `FRAME_ERR`=1, `CRC_OK`=0, `DATA_OUT` unchanged. Go to IDLE. The bit on the aborting edge is not consumed.
- The abort edge does not start a new frame, even if `ACTIVE`=1; the next frame starts on a later edge from IDLE.

## Timing
- Reset (`RST`=0, async): state=IDLE, L=SEED, count=0, `DATA_OUT`=0, and `DONE`/`CRC_OK`/`CRC_ERR`/`FRAME_ERR`=0. Reset mid-frame discards the frame with no `DONE`.
- Latency: `DONE` and the status outputs are registered on the edge that samples the last CRC bit. They are visible in the following cycle; `DONE` lasts exactly one cycle.
- Minimum frame: DATA_WIDTH + CRC_WIDTH consecutive cycles with no gap. A new frame may begin on the edge right after the `DONE` edge.
- Status outputs hold until the edge that starts the next frame, or until reset.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset: assert `RST`=0 mid-simulation → all outputs 0 within the same cycle (async), state IDLE.
- Good frame: `ACTIVE` for data 0x00 (8 bits), then immediately `Valid` with CRC 0x14 sent LSB first (0,0,1,0,1,0,0,0) → one `DONE` pulse, `CRC_OK`=1, `CRC_ERR`=0, `FRAME_ERR`=0, `DATA_OUT`=0x00.
- Bad CRC: same frame but CRC 0x15 → `DONE` pulse, `CRC_OK`=0, `CRC_ERR`=1, `FRAME_ERR`=0, `DATA_OUT`=0x00.
- Gap and back-to-back: good frame with 3 idle cycles between `ACTIVE` falling and `Valid` rising → `CRC_OK`=1. Next frame starts the cycle after `DONE` → status clears at its first bit.
- Short frame: `ACTIVE` drops after 5 data bits → `DONE` pulse, `CRC_ERR`=1, `FRAME_ERR`=1, `DATA_OUT` keeps its previous value. Repeat with `Valid` dropping after 4 CRC bits → same result.
- Reset mid-CRC: assert `RST` after 3 CRC bits → no `DONE`, outputs 0. The following good 0x00/0x14 frame → `CRC_OK`=1.
